sudoku_check_sequencer: RTL and testbench
=========================================

Name: sudoku_check_sequencer

Overview:
- Sequences a full legality check of the stored 9x9 Sudoku board after the Read phase completes, before Solve.
- Walks all 27 constraint groups: 9 rows, 9 columns, 9 boxes.
- For each group, fetches the 9 cells through the board's single synchronous read port, buffers them, and evaluates duplicates with one shared group checker.
- Reports pass/fail and the first offending group to the top-level Read/Solve/Write FSM.

Parameters:
- CELL_W, 11, cell width; bit [CELL_W-1] = empty flag, bits [CELL_W-2:0] = digit code.
- EARLY_EXIT, 1, 1 = stop at the first failing group; 0 = scan all 27 groups and keep the first failure.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a check; sampled only in IDLE or DONE.
- busy  out  1  high in FETCH and CHECK.
- done  out  1  level; high in DONE until the next accepted start or reset.
- valid  out  1  meaningful only while done=1; 1 = no duplicate found.
- bad_group  out  5  first failing group index 0..26; 31 when valid=1 or not yet known.
- rd_en  out  1  board read request.
- rd_addr  out  7  linear cell index = col*9 + row, which is the load order.
- rd_data  in  CELL_W  board data, valid the cycle after rd_en.

Behaviour:
- Reset values: busy=0, done=0, valid=0, bad_group=31, rd_en=0, rd_addr=0; state IDLE; group counter 0; slot counter 0.
- States and transitions:
  - IDLE -> FETCH on start.
  - FETCH lasts 10 cycles:
    - Cycles 0..8: rd_en=1, rd_addr = cell k of the current group.
    - rd_data for slot k is captured into buffer slot k in cycle k+1.
    - Cycle 9: rd_en=0; captures slot 8 only.
  - CHECK lasts 1 cycle: the shared checker evaluates the 9 buffered cells.
    - On duplicate: if bad_group==31, latch the group index. Then go to DONE if EARLY_EXIT=1, else continue.
    - If group==26, or an early exit fires, go to DONE. Otherwise increment group and return to FETCH.
  - DONE: done=1. valid=1 iff no failure was latched.
  - DONE -> FETCH on start. The start cycle clears done, sets valid=0 and bad_group=31, and resets group to 0.
- Group order:
  - g 0..8 = row r=g.
  - g 9..17 = column c=g-9.
  - g 18..26 = box b=g-18.
- Cell k (0..8) within a group:
  - Row: (r, k).
  - Column: (k, c).
  - Box: (3*(b/3) + k/3, 3*(b%3) + k%3).
- Duplicate rule:
  - Two cells clash iff both have the empty bit = 0 and equal digit bits [CELL_W-2:0].
  - Empty cells never clash, whatever their digit bits.
- Latency:
  - Each group takes 11 cycles.
  - A valid board raises done on the 297th rising edge after the start-accepting edge.
  - With EARLY_EXIT=1, a failure in group g raises done at edge 11*(g+1).
- start while busy: ignored; no restart and no state change.
- rst mid-operation: return to reset values next edge. The buffer contents are don't-care.
- rd_addr is registered with rd_en and holds its last value when rd_en=0.
- The board must not be written while busy=1. This block has no write port; the top-level FSM guarantees it.

Decomposition:
- Shared package sudoku_pkg:
  - CELL_W, EMPTY_BIT=10, GRID_CELLS=81, NUM_GROUPS=27, BAD_NONE=5'd31.
  - Group-kind constants ROW/COL/BOX.
  - State enum IDLE/FETCH/CHECK/DONE.
- One sub-module, sudoku_group_dup_check:
  - Purely combinational, 9 cells in, dup flag out.
  - Reused later by the solver.
  - The (group, k) -> address mapping stays inside the sequencer as a function.

Test Plan:
- All-empty board (every cell bit10=1, digit bits all 0) + start:
  - First rd_addr sequence is 0, 9, 18, ..., 72 (row 0).
  - done rises at edge 297 with valid=1, bad_group=31.
- Cell (0,0)=5 and (0,4)=5, rest empty, EARLY_EXIT=1 -> done at edge 11, valid=0, bad_group=0.
- Column 3 duplicate only, (1,3)=2 and (7,3)=2 -> done at edge 143, bad_group=12.
- Box 4 duplicate only, (3,3)=7 and (5,5)=7:
  - EARLY_EXIT=1 -> done at edge 253, bad_group=22.
  - EARLY_EXIT=0 -> done at edge 297, bad_group=22.
- Two empty cells in row 0 with equal digit bits, no other clash -> valid=1 at edge 297.
- Robustness:
  - rst pulsed during FETCH of group 5 -> next cycle busy=0, done=0, bad_group=31.
  - start pulsed again while busy -> ignored; done still rises at edge 297 of the original start.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared Sudoku definitions: cell layout, group counts, group kinds and
// the check-sequencer state encoding.
package sudoku_pkg;

   localparam int         CELL_W     = 11;
   localparam int         EMPTY_BIT  = 10;
   localparam int         GRID_CELLS = 81;
   localparam int         NUM_GROUPS = 27;
   localparam logic [4:0] BAD_NONE   = 5'd31;
   localparam logic [4:0] LAST_GROUP = 5'd26;
   localparam logic [3:0] LAST_READ  = 4'd8;
   localparam logic [3:0] LAST_SLOT  = 4'd9;

   typedef enum logic [1:0] {
      ROW = 2'd0,
      COL = 2'd1,
      BOX = 2'd2
   } group_kind_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Groups 0..8 are rows, 9..17 columns, 18..26 boxes.
   function automatic group_kind_e group_kind(input logic [4:0] g);
      if (g < 5'd9) begin
         return ROW;
      end else if (g < 5'd18) begin
         return COL;
      end else begin
         return BOX;
      end
   endfunction

endpackage

// File: rtl/sudoku_check_sequencer_if.sv
// Control/status and board-read bundle between the top-level FSM, the
// board storage and the check sequencer.
interface sudoku_check_sequencer_if #(
   parameter int CELL_W = 11
);
   logic              start;
   logic              busy;
   logic              done;
   logic              valid;
   logic [4:0]        bad_group;
   logic              rd_en;
   logic [6:0]        rd_addr;
   logic [CELL_W-1:0] rd_data;

   // Sequencer side.
   modport slave (
      input  start, rd_data,
      output busy, done, valid, bad_group, rd_en, rd_addr
   );

   // Controller / board side.
   modport master (
      output start, rd_data,
      input  busy, done, valid, bad_group, rd_en, rd_addr
   );
endinterface

// File: rtl/sudoku_group_dup_check.sv
// Combinational duplicate detector for one 9-cell constraint group.
// Empty cells (top bit set) never clash, whatever their digit bits hold.
module sudoku_group_dup_check #(
   parameter int CELL_W = 11
) (
   input  logic [8:0][CELL_W-1:0] cells,
   output logic                   dup
);

   // Compare every distinct pair of non-empty cells on their digit bits.
   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < 8; i++) begin
         for (int j = i + 1; j < 9; j++) begin
            if (!cells[i][CELL_W-1] && !cells[j][CELL_W-1] &&
                (cells[i][CELL_W-2:0] == cells[j][CELL_W-2:0])) begin
               dup = 1'b1;
            end else begin
               dup = dup;
            end
         end
      end
   end

endmodule

// File: rtl/sudoku_check_sequencer.sv
// Walks the 27 row/column/box groups of the stored board, fetching each
// group's 9 cells through the single synchronous read port into a buffer
// and running the shared duplicate checker on it.
module sudoku_check_sequencer #(
   parameter int CELL_W     = 11,
   parameter bit EARLY_EXIT = 1'b1
) (
   input logic                     clk,
   input logic                     rst,
   sudoku_check_sequencer_if.slave bus
);
   import sudoku_pkg::*;

   state_e                  state_r, state_n;
   logic [3:0]              slot_r, slot_n;
   logic [4:0]              group_r, group_n;
   logic [8:0][CELL_W-1:0]  buf_r;
   logic                    busy_r, busy_n;
   logic                    done_r, done_n;
   logic                    valid_r, valid_n;
   logic [4:0]              bad_r, bad_n;
   logic                    rd_en_r, rd_en_n;
   logic [6:0]              rd_addr_r, rd_addr_n;
   logic                    dup_s;
   logic                    stop_s;

   // Board address of cell k of group g; the board is stored column-major.
   function automatic logic [6:0] cell_addr(input logic [4:0] g, input logic [3:0] k);
      int gi, ki, r, c, b;
      gi = int'(g);
      ki = int'(k);
      case (group_kind(g))
         ROW: begin
            r = gi;
            c = ki;
         end
         COL: begin
            r = ki;
            c = gi - 9;
         end
         BOX: begin
            b = gi - 18;
            r = 3 * (b / 3) + ki / 3;
            c = 3 * (b % 3) + ki % 3;
         end
         default: begin
            r = 0;
            c = 0;
         end
      endcase
      return 7'(c * 9 + r);
   endfunction

   sudoku_group_dup_check #(.CELL_W(CELL_W)) u_dup (
      .cells (buf_r),
      .dup   (dup_s)
   );

   // Next-state and next-output logic for the sequencing FSM.
   always_comb begin
      state_n   = state_r;
      slot_n    = slot_r;
      group_n   = group_r;
      done_n    = done_r;
      valid_n   = valid_r;
      bad_n     = bad_r;
      rd_en_n   = rd_en_r;
      rd_addr_n = rd_addr_r;
      stop_s    = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (bus.start) begin
               state_n   = FETCH;
               slot_n    = 4'd0;
               group_n   = 5'd0;
               done_n    = 1'b0;
               valid_n   = 1'b0;
               bad_n     = BAD_NONE;
               rd_en_n   = 1'b1;
               rd_addr_n = cell_addr(5'd0, 4'd0);
            end else begin
               state_n = state_r;
            end
         end
         FETCH: begin
            if (slot_r == LAST_SLOT) begin
               state_n = CHECK;
               slot_n  = 4'd0;
            end else begin
               slot_n = slot_r + 4'd1;
               // The request for slot k+1 is issued while slot k is in flight.
               if (slot_r < LAST_READ) begin
                  rd_en_n   = 1'b1;
                  rd_addr_n = cell_addr(group_r, slot_r + 4'd1);
               end else begin
                  rd_en_n = 1'b0;
               end
            end
         end
         CHECK: begin
            if (dup_s && (bad_r == BAD_NONE)) begin
               bad_n = group_r;
            end else begin
               bad_n = bad_r;
            end
            stop_s = (dup_s && EARLY_EXIT) || (group_r == LAST_GROUP);
            if (stop_s) begin
               state_n = DONE;
               done_n  = 1'b1;
               valid_n = (bad_n == BAD_NONE);
            end else begin
               state_n   = FETCH;
               slot_n    = 4'd0;
               group_n   = group_r + 5'd1;
               rd_en_n   = 1'b1;
               rd_addr_n = cell_addr(group_r + 5'd1, 4'd0);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n == FETCH) || (state_n == CHECK);
   end

   // State and registered-output update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         slot_r    <= 4'd0;
         group_r   <= 5'd0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         valid_r   <= 1'b0;
         bad_r     <= BAD_NONE;
         rd_en_r   <= 1'b0;
         rd_addr_r <= 7'd0;
      end else begin
         state_r   <= state_n;
         slot_r    <= slot_n;
         group_r   <= group_n;
         busy_r    <= busy_n;
         done_r    <= done_n;
         valid_r   <= valid_n;
         bad_r     <= bad_n;
         rd_en_r   <= rd_en_n;
         rd_addr_r <= rd_addr_n;
      end
   end

   // Capture returning read data: slot k arrives during FETCH cycle k+1.
   always_ff @(posedge clk) begin
      if ((state_r == FETCH) && (slot_r != 4'd0)) begin
         buf_r[slot_r - 4'd1] <= bus.rd_data;
      end else begin
         buf_r <= buf_r;
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.valid     = valid_r;
   assign bus.bad_group = bad_r;
   assign bus.rd_en     = rd_en_r;
   assign bus.rd_addr   = rd_addr_r;

endmodule

// File: tb/tb_sudoku_check_sequencer.sv
// Bench for sudoku_check_sequencer: two instances (early exit on / off)
// share one board; a board-level reference model predicts every cycle.
module tb_sudoku_check_sequencer;

   logic clk = 1'b0;
   logic rst;
   logic start_s;
   logic [10:0] board [9][9];   // board[row][col]
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sudoku_check_sequencer_if #(.CELL_W(11)) bus_ee ();
   sudoku_check_sequencer_if #(.CELL_W(11)) bus_all ();

   assign bus_ee.start  = start_s;
   assign bus_all.start = start_s;

   sudoku_check_sequencer #(.CELL_W(11), .EARLY_EXIT(1'b1)) dut_ee (
      .clk (clk), .rst (rst), .bus (bus_ee)
   );
   sudoku_check_sequencer #(.CELL_W(11), .EARLY_EXIT(1'b0)) dut_all (
      .clk (clk), .rst (rst), .bus (bus_all)
   );

   // Synchronous board read ports, address = col*9 + row.
   always @(posedge clk) begin
      if (bus_ee.rd_en)  bus_ee.rd_data  <= board[bus_ee.rd_addr % 7'd9][bus_ee.rd_addr / 7'd9];
      if (bus_all.rd_en) bus_all.rd_data <= board[bus_all.rd_addr % 7'd9][bus_all.rd_addr / 7'd9];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Address of cell k of group g, straight from the group definitions.
   function automatic int exp_addr(input int g, input int k);
      int r, c, b;
      if (g < 9) begin
         r = g; c = k;
      end else if (g < 18) begin
         r = k; c = g - 9;
      end else begin
         b = g - 18;
         r = 3 * (b / 3) + k / 3;
         c = 3 * (b % 3) + k % 3;
      end
      return c * 9 + r;
   endfunction

   // First group containing two non-empty cells with the same digit code.
   function automatic int model_first_fail();
      int seen [int];
      bit member;
      for (int g = 0; g < 27; g++) begin
         seen.delete();
         for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
               if (g < 9)       member = (r == g);
               else if (g < 18) member = (c == g - 9);
               else             member = ((r / 3) * 3 + c / 3 == g - 18);
               if (member && !board[r][c][10]) begin
                  if (seen.exists(int'(board[r][c][9:0]))) return g;
                  seen[int'(board[r][c][9:0])] = 1;
               end
            end
         end
      end
      return 31;
   endfunction

   task automatic clear_board(input bit garbage);
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++)
            board[r][c] = {1'b1, garbage ? 10'($urandom_range(0, 1023)) : 10'd0};
   endtask

   // Expected view of one instance, n edges after the start-accepting edge.
   task automatic chk_inst(input string tag, input int n, input int end_n, input int bad,
                           input logic busy, input logic done, input logic valid,
                           input logic [4:0] bad_group, input logic rd_en, input logic [6:0] rd_addr);
      int g, p;
      if (n < end_n) begin
         g = n / 11;
         p = n % 11;
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_done"}, done, 0);
         chk({tag, "_rd_en"}, rd_en, (p <= 8) ? 1 : 0);
         chk({tag, "_rd_addr"}, rd_addr, exp_addr(g, (p <= 8) ? p : 8));
      end else begin
         chk({tag, "_busy_end"}, busy, 0);
         chk({tag, "_done_end"}, done, 1);
         chk({tag, "_valid"}, valid, (bad == 31) ? 1 : 0);
         chk({tag, "_bad_group"}, bad_group, bad);
         chk({tag, "_rd_en_end"}, rd_en, 0);
         chk({tag, "_rd_addr_hold"}, rd_addr, exp_addr(end_n / 11 - 1, 8));
      end
   endtask

   // One full check on both instances; optional extra start while busy.
   task automatic run_check(input int mid_start);
      int ff, end_ee;
      ff     = model_first_fail();
      end_ee = (ff == 31) ? 297 : 11 * (ff + 1);
      start_s = 1'b1;
      @(negedge clk);
      for (int n = 0; n <= 299; n++) begin
         chk_inst("ee", n, end_ee, ff, bus_ee.busy, bus_ee.done, bus_ee.valid,
                  bus_ee.bad_group, bus_ee.rd_en, bus_ee.rd_addr);
         chk_inst("all", n, 297, ff, bus_all.busy, bus_all.done, bus_all.valid,
                  bus_all.bad_group, bus_all.rd_en, bus_all.rd_addr);
         start_s = (n == mid_start && n + 1 < end_ee) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ee_busy"}, bus_ee.busy, 0);
      chk({tag, "_ee_done"}, bus_ee.done, 0);
      chk({tag, "_ee_valid"}, bus_ee.valid, 0);
      chk({tag, "_ee_bad"}, bus_ee.bad_group, 31);
      chk({tag, "_ee_rd_en"}, bus_ee.rd_en, 0);
      chk({tag, "_ee_rd_addr"}, bus_ee.rd_addr, 0);
      chk({tag, "_all_busy"}, bus_all.busy, 0);
      chk({tag, "_all_done"}, bus_all.done, 0);
      chk({tag, "_all_bad"}, bus_all.bad_group, 31);
      chk({tag, "_all_rd_en"}, bus_all.rd_en, 0);
   endtask

   initial begin
      int mode, cnt, ee_end;
      rst     = 1'b1;
      start_s = 1'b0;
      clear_board(1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);

      // Model pins: row-0 fetch order and the box/column address mapping.
      for (int k = 0; k < 9; k++) chk("pin_row0_addr", exp_addr(0, k), 9 * k);
      chk("pin_box4_k8", exp_addr(22, 8), 50);
      chk("pin_col3_k1", exp_addr(12, 1), 28);

      // All-empty board; a second start mid-run must be ignored.
      chk("pin_empty", model_first_fail(), 31);
      run_check(100);

      // Row 0 clash.
      clear_board(1'b0);
      board[0][0] = {1'b0, 10'd5};
      board[0][4] = {1'b0, 10'd5};
      chk("pin_row0", model_first_fail(), 0);
      run_check(5);

      // Column 3 clash.
      clear_board(1'b0);
      board[1][3] = {1'b0, 10'd2};
      board[7][3] = {1'b0, 10'd2};
      chk("pin_col3", model_first_fail(), 12);
      run_check(-1);

      // Box 4 clash.
      clear_board(1'b0);
      board[3][3] = {1'b0, 10'd7};
      board[5][5] = {1'b0, 10'd7};
      chk("pin_box4", model_first_fail(), 22);
      run_check(-1);

      // Empty cells with equal digit bits never clash.
      clear_board(1'b0);
      board[0][0] = {1'b1, 10'd3};
      board[0][1] = {1'b1, 10'd3};
      chk("pin_empty_eq", model_first_fail(), 31);
      run_check(-1);

      // Reset during FETCH of group 5.
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      repeat (57) @(negedge clk);
      chk("rst_mid_busy_before", bus_ee.busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_state("rst_mid");
      rst = 1'b0;
      @(negedge clk);

      // Randomized boards.
      for (int t = 0; t < 18; t++) begin
         mode = $urandom_range(0, 2);
         clear_board(1'b1);
         if (mode == 1) begin
            cnt = $urandom_range(1, 6);
            for (int i = 0; i < cnt; i++)
               board[$urandom_range(0, 8)][$urandom_range(0, 8)] =
                  {1'b0, ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                     : 10'($urandom_range(1, 9))};
         end else begin
            for (int r = 0; r < 9; r++)
               for (int c = 0; c < 9; c++)
                  if ($urandom_range(0, 1) == 1)
                     board[r][c] = {1'b0, 10'((r * 3 + r / 3 + c) % 9 + 1)};
            if (mode == 2)
               board[$urandom_range(0, 8)][$urandom_range(0, 8)] = {1'b0, 10'($urandom_range(1, 9))};
         end
         ee_end = (model_first_fail() == 31) ? 297 : 11 * (model_first_fail() + 1);
         run_check(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, ee_end - 2)) : -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
